stage_scoreboard: RTL and testbench
===================================

# stage_scoreboard

Parametrised lockstep scoreboard comparing per-stage signal bundles from the pipelined CPU against the cycle model across NUM_CH independent channels. It tolerates bounded arrival skew between the two sides through per-channel FIFOs and counts mismatches. It also captures the first failing transaction and resolves run completion from both halt signals, with timeout detection. It sits between the CPU/model pair and the verification logger and replaces the fixed per-stage, same-cycle compare with a buffered, synthesizable checker.

## Interface
- NUM_CH, 8, number of compared channels (one per pipeline stage/boundary), 1–16
- WIDTH, 64, bits per channel bundle
- DEPTH, 4, entries per side per channel; power of two, ≥2
- HLT_SKEW, 16, max cycles between dut_hlt and ref_hlt before a halt mismatch is flagged
- TIMEOUT, 1000000, cycles after reset without done before timeout is flagged
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- dut_valid  in  NUM_CH  per-channel DUT bundle strobe
- dut_data  in  NUM_CH*WIDTH  DUT bundles; channel i occupies bits [i*WIDTH +: WIDTH]
- ref_valid  in  NUM_CH  per-channel model bundle strobe
- ref_data  in  NUM_CH*WIDTH  model bundles, same packing
- dut_hlt  in  1  DUT halt (level)
- ref_hlt  in  1  model halt (level)
- mismatch  out  NUM_CH  one-cycle pulse per channel whose compared pair differed
- err_count  out  16  total mismatches, saturating at 16'hFFFF
- first_err_valid  out  1  sticky; first mismatch captured
- first_err_ch  out  4  channel of the first mismatch
- first_err_dut  out  WIDTH  DUT bundle of the first mismatch
- first_err_ref  out  WIDTH  model bundle of the first mismatch
- overflow  out  NUM_CH  sticky per channel; a push hit a full FIFO
- hlt_mismatch  out  1  sticky; the halts diverged beyond HLT_SKEW
- done  out  1  sticky; both sides halted and all FIFOs drained
- timeout  out  1  sticky; TIMEOUT reached with done low

## Operation
- Each channel has two FIFOs, DUT-side and ref-side, each DEPTH deep.
  - x_valid high pushes x_data into that side's FIFO.
- Compare rule: on any edge where a channel has both heads non-empty, pop both and compare the full WIDTH bits.
  - Inequality sets that channel's mismatch bit for the following cycle.
- Push and pop on the same edge are legal, including when the FIFO is full: the pop frees the slot and the push succeeds.
- Push to a full FIFO with no pop on the same edge:
  - data is dropped;
  - overflow[i] sets;
  - err_count is unaffected.
- err_count adds the popcount of the mismatches produced on each edge and saturates at FFFF; it never wraps.
- First-error capture: on the first edge producing any mismatch, latch the lowest-index mismatching channel and its two bundles, and set first_err_valid.
  - These outputs are frozen afterward until reset.
- Halt tracking:
  - dut_hlt and ref_hlt are each latched sticky.
  - A skew counter runs while exactly one sticky halt is set.
  - When the counter reaches HLT_SKEW, hlt_mismatch sets.
  - The counter stops once both sticky halts are set.
- done sets on the first edge where both sticky halts are set and every FIFO is empty.
  - Compares still pending at halt must drain first.
- Timeout:
  - A cycle counter, sized to hold TIMEOUT, counts from reset.
  - When it reaches TIMEOUT with done low, timeout sets and the counter holds.
  - Once done is set, timeout never asserts.
- Reset: all FIFOs empty, and every output, counter and sticky flag is 0.
  - A reset mid-run discards all buffered entries.
  - Reset is synchronous and takes effect at the edge where rst_n is sampled low.

## Timing
- Bundle pair pushed at edge E (both sides in the same cycle): compare at E+1; mismatch visible in the cycle after E+1.
  - Latency is 2 edges from the sampled strobe.
- Skewed arrival: the compare occurs at the edge after the later side's push.
- The mismatch pulse width is exactly one cycle per compared pair; back-to-back pairs give back-to-back pulses.
- err_count, first_err_* and done update on the same edge as the mismatch register.
- Inputs carry no backpressure. The producer ensures skew stays below DEPTH entries; otherwise overflow flags it.

## Test plan
- Identical streams: push 0x1234 on both sides of ch0 for 100 cycles → mismatch=0, err_count=0, first_err_valid=0.
- Skew plus mismatch: push DUT ch3 = 0xAA at cycle 10 and ref ch3 = 0xAB at cycle 12 → mismatch[3] pulses once two edges after the ref strobe; err_count=1; first_err_ch=3, first_err_dut=0xAA, first_err_ref=0xAB.
- Simultaneous multi-channel error: ch1, ch5 and ch6 all differ on the same edge → err_count += 3; first_err_ch=1.
- Overflow and saturation:
  - DEPTH=4: push 5 DUT entries to ch2 with no ref entries → overflow[2]=1 and the 5th entry is dropped.
  - Preload err_count=FFFE, then force 3 mismatches → err_count=FFFF.
- Halt handling: dut_hlt at cycle 50, ref_hlt at 60 with HLT_SKEW=16, FIFOs drained → done=1, hlt_mismatch=0. A repeat run with ref_hlt at 70 → hlt_mismatch=1.
- Timeout and reset: TIMEOUT=200 with no halts → timeout=1 at cycle 200. Assert rst_n=0 mid-run with entries queued → all outputs 0 and FIFOs empty after the reset edge.

Source files
------------

// File: rtl/stage_scoreboard.sv
// stage_scoreboard: buffered lockstep checker between CPU and cycle model.
// Per-channel skew FIFOs, mismatch counting, first-error capture, halt/timeout.
module stage_scoreboard #(
    parameter int NUM_CH   = 8,
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 4,
    parameter int HLT_SKEW = 16,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       dut_valid,
    input  logic [NUM_CH*WIDTH-1:0] dut_data,
    input  logic [NUM_CH-1:0]       ref_valid,
    input  logic [NUM_CH*WIDTH-1:0] ref_data,
    input  logic                    dut_hlt,
    input  logic                    ref_hlt,
    output logic [NUM_CH-1:0]       mismatch,
    output logic [15:0]             err_count,
    output logic                    first_err_valid,
    output logic [3:0]              first_err_ch,
    output logic [WIDTH-1:0]        first_err_dut,
    output logic [WIDTH-1:0]        first_err_ref,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    hlt_mismatch,
    output logic                    done,
    output logic                    timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(HLT_SKEW + 1);

    logic [WIDTH-1:0]  d_mem    [NUM_CH][DEPTH];
    logic [WIDTH-1:0]  r_mem    [NUM_CH][DEPTH];
    logic [AW-1:0]     d_rp     [NUM_CH];
    logic [AW-1:0]     d_wp     [NUM_CH];
    logic [AW-1:0]     r_rp     [NUM_CH];
    logic [AW-1:0]     r_wp     [NUM_CH];
    logic [CW-1:0]     d_cnt    [NUM_CH];
    logic [CW-1:0]     r_cnt    [NUM_CH];
    logic [CW-1:0]     d_cnt_nx [NUM_CH];
    logic [CW-1:0]     r_cnt_nx [NUM_CH];
    logic [WIDTH-1:0]  d_head   [NUM_CH];
    logic [WIDTH-1:0]  r_head   [NUM_CH];

    logic [NUM_CH-1:0] cmp;
    logic [NUM_CH-1:0] diff;
    logic [NUM_CH-1:0] d_push;
    logic [NUM_CH-1:0] r_push;
    logic [NUM_CH-1:0] d_drop;
    logic [NUM_CH-1:0] r_drop;

    logic [4:0]        diff_pc;
    logic [3:0]        low_ch;
    logic [WIDTH-1:0]  low_d;
    logic [WIDTH-1:0]  low_r;
    logic [16:0]       err_sum;
    logic              all_empty_nx;
    logic              hs_d;
    logic              hs_r;
    logic              hs_d_nx;
    logic              hs_r_nx;
    logic              done_nx;
    logic [SW-1:0]     skew_cnt;
    logic [TW-1:0]     t_cnt;

    // FIFO heads and which channels compare on this edge
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            d_head[i] = d_mem[i][d_rp[i]];
            r_head[i] = r_mem[i][r_rp[i]];
            cmp[i]    = (d_cnt[i] != '0) && (r_cnt[i] != '0);
        end
    end

    // push acceptance (a same-edge pop frees a full slot) and next counts
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            diff[i]     = cmp[i] && (d_head[i] != r_head[i]);
            d_push[i]   = dut_valid[i] &&
                          ((d_cnt[i] != CW'(DEPTH)) || cmp[i]);
            r_push[i]   = ref_valid[i] &&
                          ((r_cnt[i] != CW'(DEPTH)) || cmp[i]);
            d_drop[i]   = dut_valid[i] &&
                          (d_cnt[i] == CW'(DEPTH)) && !cmp[i];
            r_drop[i]   = ref_valid[i] &&
                          (r_cnt[i] == CW'(DEPTH)) && !cmp[i];
            d_cnt_nx[i] = d_cnt[i] + CW'(d_push[i]) - CW'(cmp[i]);
            r_cnt_nx[i] = r_cnt[i] + CW'(r_push[i]) - CW'(cmp[i]);
        end
    end

    // mismatch popcount, lowest failing channel, drain and halt status
    always_comb begin
        diff_pc      = '0;
        low_ch       = '0;
        low_d        = '0;
        low_r        = '0;
        all_empty_nx = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            diff_pc = diff_pc + 5'(diff[i]);
            if (diff[i]) begin
                low_ch = 4'(i);
                low_d  = d_head[i];
                low_r  = r_head[i];
            end
            if ((d_cnt_nx[i] != '0) || (r_cnt_nx[i] != '0)) begin
                all_empty_nx = 1'b0;
            end
        end
        err_sum = {1'b0, err_count} + 17'(diff_pc);
        hs_d_nx = hs_d | dut_hlt;
        hs_r_nx = hs_r | ref_hlt;
        done_nx = done | (hs_d_nx & hs_r_nx & all_empty_nx);
    end

    // FIFO storage writes; contents are don't-care while empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (d_push[i]) begin
                d_mem[i][d_wp[i]] <= dut_data[i*WIDTH +: WIDTH];
            end
            if (r_push[i]) begin
                r_mem[i][r_wp[i]] <= ref_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_rp[i]  <= '0;
                d_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_wp[i]  <= '0;
                d_cnt[i] <= '0;
                r_cnt[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmp[i]) begin
                    d_rp[i] <= d_rp[i] + AW'(1);
                    r_rp[i] <= r_rp[i] + AW'(1);
                end
                if (d_push[i]) d_wp[i] <= d_wp[i] + AW'(1);
                if (r_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
                d_cnt[i] <= d_cnt_nx[i];
                r_cnt[i] <= r_cnt_nx[i];
            end
            overflow <= overflow | d_drop | r_drop;
        end
    end

    // compare results: pulse, saturating count, frozen first error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_dut   <= '0;
            first_err_ref   <= '0;
        end else begin
            mismatch <= diff;
            if (err_sum[16]) err_count <= 16'hFFFF;
            else             err_count <= err_sum[15:0];
            if (!first_err_valid && (diff != '0)) begin
                first_err_valid <= 1'b1;
                first_err_ch    <= low_ch;
                first_err_dut   <= low_d;
                first_err_ref   <= low_r;
            end
        end
    end

    // sticky halts, skew window and completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_d         <= 1'b0;
            hs_r         <= 1'b0;
            skew_cnt     <= '0;
            hlt_mismatch <= 1'b0;
            done         <= 1'b0;
        end else begin
            hs_d <= hs_d_nx;
            hs_r <= hs_r_nx;
            done <= done_nx;
            if ((hs_d ^ hs_r) && (skew_cnt != SW'(HLT_SKEW))) begin
                skew_cnt <= skew_cnt + SW'(1);
                if (skew_cnt == SW'(HLT_SKEW - 1)) begin
                    hlt_mismatch <= 1'b1;
                end
            end
        end
    end

    // run-length watchdog, suppressed once the run completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_cnt   <= '0;
            timeout <= 1'b0;
        end else if (t_cnt != TW'(TIMEOUT)) begin
            t_cnt <= t_cnt + TW'(1);
            if ((t_cnt == TW'(TIMEOUT - 1)) && !done_nx) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage_scoreboard.sv
// tb_stage_scoreboard: directed and random checks of stage_scoreboard
// against a queue-based reference model.
module tb_stage_scoreboard;

    localparam int NC = 8;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int HS = 16;
    localparam int TO = 200;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   dut_valid;
    logic [NC*W-1:0] dut_data;
    logic [NC-1:0]   ref_valid;
    logic [NC*W-1:0] ref_data;
    logic            dut_hlt;
    logic            ref_hlt;
    logic [NC-1:0]   mismatch;
    logic [15:0]     err_count;
    logic            first_err_valid;
    logic [3:0]      first_err_ch;
    logic [W-1:0]    first_err_dut;
    logic [W-1:0]    first_err_ref;
    logic [NC-1:0]   overflow;
    logic            hlt_mismatch;
    logic            done;
    logic            timeout;

    stage_scoreboard #(
        .NUM_CH(NC), .WIDTH(W), .DEPTH(D),
        .HLT_SKEW(HS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dut_valid(dut_valid), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .dut_hlt(dut_hlt), .ref_hlt(ref_hlt),
        .mismatch(mismatch), .err_count(err_count),
        .first_err_valid(first_err_valid),
        .first_err_ch(first_err_ch),
        .first_err_dut(first_err_dut),
        .first_err_ref(first_err_ref),
        .overflow(overflow), .hlt_mismatch(hlt_mismatch),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  q_d [NC][$];
    logic [W-1:0]  q_r [NC][$];
    int            m_err, m_edge, m_td, m_tr;
    logic          m_fev, m_hm, m_done, m_to;
    logic [3:0]    m_fch;
    logic [W-1:0]  m_fd, m_fr;
    logic [NC-1:0] m_ovf, m_mm;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] pd [NC];
        logic [W-1:0] pr [NC];
        int first, second;
        bit empty;
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                q_d[c].delete();
                q_r[c].delete();
            end
            m_err = 0; m_edge = 0; m_td = -1; m_tr = -1;
            m_fev = 0; m_hm = 0; m_done = 0; m_to = 0;
            m_fch = '0; m_fd = '0; m_fr = '0;
            m_ovf = '0; m_mm = '0;
            return;
        end
        m_edge++;
        m_mm = '0;
        for (int c = 0; c < NC; c++) begin
            pd[c] = '0;
            pr[c] = '0;
            if (q_d[c].size() > 0 && q_r[c].size() > 0) begin
                pd[c] = q_d[c].pop_front();
                pr[c] = q_r[c].pop_front();
                m_mm[c] = (pd[c] != pr[c]);
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (dut_valid[c]) begin
                if (q_d[c].size() < D) q_d[c].push_back(dut_data[c*W +: W]);
                else m_ovf[c] = 1'b1;
            end
            if (ref_valid[c]) begin
                if (q_r[c].size() < D) q_r[c].push_back(ref_data[c*W +: W]);
                else m_ovf[c] = 1'b1;
            end
        end
        m_err = m_err + $countones(m_mm);
        if (m_err > 65535) m_err = 65535;
        if (!m_fev && m_mm != '0) begin
            m_fev = 1'b1;
            for (int c = NC - 1; c >= 0; c--) begin
                if (m_mm[c]) begin
                    m_fch = 4'(c);
                    m_fd  = pd[c];
                    m_fr  = pr[c];
                end
            end
        end
        if (dut_hlt && m_td < 0) m_td = m_edge;
        if (ref_hlt && m_tr < 0) m_tr = m_edge;
        if (m_td >= 0 || m_tr >= 0) begin
            if (m_td < 0) first = m_tr;
            else if (m_tr < 0) first = m_td;
            else first = (m_td < m_tr) ? m_td : m_tr;
            if (m_td < 0 || m_tr < 0) second = m_edge;
            else second = (m_td < m_tr) ? m_tr : m_td;
            if (second - first >= HS) m_hm = 1'b1;
        end
        empty = 1;
        for (int c = 0; c < NC; c++) begin
            if (q_d[c].size() != 0 || q_r[c].size() != 0) empty = 0;
        end
        if (m_td >= 0 && m_tr >= 0 && empty) m_done = 1'b1;
        if (m_edge == TO && !m_done) m_to = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("mismatch", 64'(mismatch), 64'(m_mm));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("first_err_valid", 64'(first_err_valid), 64'(m_fev));
        chk("first_err_ch", 64'(first_err_ch), 64'(m_fch));
        chk("first_err_dut", 64'(first_err_dut), 64'(m_fd));
        chk("first_err_ref", 64'(first_err_ref), 64'(m_fr));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("hlt_mismatch", 64'(hlt_mismatch), 64'(m_hm));
        chk("done", 64'(done), 64'(m_done));
        chk("timeout", 64'(timeout), 64'(m_to));
    endtask

    task automatic idle();
        dut_valid = '0;
        ref_valid = '0;
        dut_data  = '0;
        ref_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        dut_hlt = 1'b0;
        ref_hlt = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        dut_hlt = 1'b0;
        ref_hlt = 1'b0;
        idle();

        // reset state
        do_reset();
        chk("rst_err_count", 64'(err_count), 64'h0);
        chk("rst_done", 64'(done), 64'h0);

        // identical streams on ch0
        for (int c = 0; c < 100; c++) begin
            dut_valid[0] = 1'b1;
            ref_valid[0] = 1'b1;
            dut_data[15:0] = 16'h1234;
            ref_data[15:0] = 16'h1234;
            tick();
        end
        idle();
        tick();
        tick();
        chk("ident_err_count", 64'(err_count), 64'h0);
        chk("ident_fev", 64'(first_err_valid), 64'h0);

        // skewed arrival with a mismatch on ch3
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            idle();
            if (c == 10) begin
                dut_valid[3] = 1'b1;
                dut_data[3*W +: W] = 16'h00AA;
            end
            if (c == 12) begin
                ref_valid[3] = 1'b1;
                ref_data[3*W +: W] = 16'h00AB;
            end
            tick();
            if (c == 12) chk("skew_pre", 64'(mismatch), 64'h00);
            if (c == 13) chk("skew_pulse", 64'(mismatch), 64'h08);
            if (c == 14) chk("skew_post", 64'(mismatch), 64'h00);
        end
        chk("skew_err_count", 64'(err_count), 64'h1);
        chk("skew_ch", 64'(first_err_ch), 64'h3);
        chk("skew_dut", 64'(first_err_dut), 64'hAA);
        chk("skew_ref", 64'(first_err_ref), 64'hAB);

        // simultaneous errors on ch1, ch5, ch6
        do_reset();
        dut_valid = '1;
        ref_valid = '1;
        for (int c = 0; c < NC; c++) begin
            dut_data[c*W +: W] = 16'(c);
            ref_data[c*W +: W] = (c == 1 || c == 5 || c == 6)
                                 ? 16'(c + 64) : 16'(c);
        end
        tick();
        idle();
        tick();
        chk("multi_mm", 64'(mismatch), 64'h62);
        chk("multi_err_count", 64'(err_count), 64'h3);
        chk("multi_ch", 64'(first_err_ch), 64'h1);
        tick();

        // overflow on ch2: fifth entry dropped
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle();
            dut_valid[2] = 1'b1;
            dut_data[2*W +: W] = 16'(16'h100 + c);
            tick();
        end
        chk("ovf_flag", 64'(overflow), 64'h04);
        for (int c = 0; c < 5; c++) begin
            idle();
            ref_valid[2] = 1'b1;
            ref_data[2*W +: W] = 16'(16'h100 + c);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("ovf_err_count", 64'(err_count), 64'h0);

        // halts within skew, then beyond skew
        for (int run = 0; run < 2; run++) begin
            do_reset();
            for (int c = 1; c <= 210; c++) begin
                idle();
                if (c < 40) begin
                    for (int k = 0; k < NC; k++) begin
                        dut_valid[k] = 1'($urandom_range(0, 1));
                        ref_valid[k] = dut_valid[k];
                        dut_data[k*W +: W] = 16'($urandom);
                        ref_data[k*W +: W] = dut_data[k*W +: W];
                    end
                end
                dut_hlt = (c >= 50);
                ref_hlt = (c >= ((run == 0) ? 60 : 70));
                tick();
                if (c == 80) begin
                    chk("halt_done", 64'(done), 64'h1);
                    chk("halt_hm", 64'(hlt_mismatch), 64'(run));
                end
            end
            chk("halt_no_timeout", 64'(timeout), 64'h0);
        end

        // timeout with no halts
        do_reset();
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == TO - 1) chk("to_before", 64'(timeout), 64'h0);
        end
        chk("to_at", 64'(timeout), 64'h1);

        // random traffic with random halts
        do_reset();
        for (int c = 1; c <= 600; c++) begin
            for (int k = 0; k < NC; k++) begin
                dut_valid[k] = 1'($urandom_range(0, 1));
                ref_valid[k] = 1'($urandom_range(0, 1));
                dut_data[k*W +: W] = 16'($urandom_range(0, 3));
                ref_data[k*W +: W] = 16'($urandom_range(0, 3));
            end
            if (c > 500) idle();
            dut_hlt = dut_hlt | ($urandom_range(0, 60) == 0);
            ref_hlt = ref_hlt | ($urandom_range(0, 60) == 0);
            tick();
        end

        // mid-run reset discards queued entries
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NC; k++) begin
                dut_valid[k] = 1'b1;
                dut_data[k*W +: W] = 16'($urandom);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        chk("mrst_err_count", 64'(err_count), 64'h0);
        chk("mrst_mm", 64'(mismatch), 64'h0);
        chk("mrst_ovf", 64'(overflow), 64'h0);
        for (int c = 0; c < 3; c++) begin
            ref_valid = '1;
            for (int k = 0; k < NC; k++) begin
                ref_data[k*W +: W] = 16'hBEEF;
            end
            tick();
        end
        idle();
        repeat (3) tick();
        chk("mrst_after_err", 64'(err_count), 64'h0);

        // err_count saturation
        do_reset();
        dut_valid = '1;
        ref_valid = '1;
        for (int c = 0; c < 8300; c++) begin
            for (int k = 0; k < NC; k++) begin
                dut_data[k*W +: W] = 16'(c);
                ref_data[k*W +: W] = ~16'(c);
            end
            tick();
        end
        idle();
        tick();
        chk("sat_err_count", 64'(err_count), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
